ps2_command_decoder: RTL

- Parametrised next-generation keyboard command decoder for the Game-of-Life front end. Sits between the PS/2 `keyboard` scancode receiver and the life engine / pattern loader.
- Adds several features:
  - decodes PS/2 set-2 prefixes, so key releases (F0) and extended keys (E0) are handled correctly;
  - accepts multi-digit decimal pattern IDs;
  - provides a saturating speed setting from the arrow keys;
  - stretches control pulses to a configurable length.

---
 rtl/ps2_command_decoder.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ps2_command_decoder.sv
// PS/2 set-2 keyboard command decoder for the Game-of-Life front end.
// Handles E0/F0 prefixes, decimal pattern IDs, arrow-key speed and stretched command pulses.
module ps2_command_decoder #(
  parameter int unsigned PULSE_CYCLES = 65536,
  parameter int unsigned ID_WIDTH     = 8,
  parameter int unsigned ID_DIGITS    = 2,
  parameter int unsigned SPEED_WIDTH  = 3
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic [7:0]             scancode,
  input  logic                   scancode_valid,
  output logic                   start,
  output logic                   pause,
  output logic                   clear,
  output logic                   running,
  output logic [ID_WIDTH-1:0]    file_id,
  output logic [SPEED_WIDTH-1:0] speed
);

  localparam int unsigned CntW = $clog2(PULSE_CYCLES + 1);
  localparam int unsigned DigW = $clog2(ID_DIGITS + 1);
  localparam int unsigned MulW = ID_WIDTH + 4;

  typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

  state_e                 r_state, w_state_next;
  logic                   w_is_prefix, w_make, w_ext_make;
  logic                   w_digit_valid, w_is_start, w_is_pause, w_is_clear, w_is_bksp;
  logic                   w_is_up, w_is_down;
  logic [3:0]             w_digit;
  logic [MulW-1:0]        w_mul;
  logic [ID_WIDTH-1:0]    w_sat;
  logic [ID_WIDTH-1:0]    r_entry, r_file_id;
  logic [DigW-1:0]        r_digit_cnt;
  logic                   r_running;
  logic [SPEED_WIDTH-1:0] r_speed;
  logic [2:0]             r_cmd;
  logic [CntW-1:0]        r_pulse_cnt;

  assign w_is_prefix = (scancode == 8'hE0) || (scancode == 8'hF0);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (scancode_valid) begin
      if (scancode == 8'hE0) begin
        w_state_next = StExt;
      end else if (scancode == 8'hF0) begin
        case (r_state)
          StIdle:  w_state_next = StBrk;
          StExt:   w_state_next = StExtBrk;
          default: w_state_next = r_state;
        endcase
      end else begin
        w_state_next = StIdle;
      end
    end
  end

  // Non-prefix bytes seen in a break state are releases and produce no action.
  always_comb begin
    w_make     = scancode_valid && !w_is_prefix && (r_state == StIdle);
    w_ext_make = scancode_valid && !w_is_prefix && (r_state == StExt);
  end

  always_comb begin
    w_digit_valid = 1'b0;
    w_digit       = 4'd0;
    w_is_start    = 1'b0;
    w_is_pause    = 1'b0;
    w_is_clear    = 1'b0;
    w_is_bksp     = 1'b0;
    if (w_make) begin
      case (scancode)
        8'h45: begin w_digit_valid = 1'b1; w_digit = 4'd0; end
        8'h16: begin w_digit_valid = 1'b1; w_digit = 4'd1; end
        8'h1E: begin w_digit_valid = 1'b1; w_digit = 4'd2; end
        8'h26: begin w_digit_valid = 1'b1; w_digit = 4'd3; end
        8'h25: begin w_digit_valid = 1'b1; w_digit = 4'd4; end
        8'h2E: begin w_digit_valid = 1'b1; w_digit = 4'd5; end
        8'h36: begin w_digit_valid = 1'b1; w_digit = 4'd6; end
        8'h3D: begin w_digit_valid = 1'b1; w_digit = 4'd7; end
        8'h3E: begin w_digit_valid = 1'b1; w_digit = 4'd8; end
        8'h46: begin w_digit_valid = 1'b1; w_digit = 4'd9; end
        8'h5A: w_is_start = 1'b1;
        8'h4D: w_is_pause = 1'b1;
        8'h2D: w_is_clear = 1'b1;
        8'h66: w_is_bksp  = 1'b1;
        default: ;
      endcase
    end
  end

  assign w_is_up   = w_ext_make && (scancode == 8'h75);
  assign w_is_down = w_ext_make && (scancode == 8'h72);

  // Four spare bits hold the worst case (all-ones * 10 + 9) before saturation.
  assign w_mul = MulW'(r_entry) * MulW'(10) + MulW'(w_digit);
  assign w_sat = (w_mul > MulW'({ID_WIDTH{1'b1}})) ? {ID_WIDTH{1'b1}} : w_mul[ID_WIDTH-1:0];

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_entry     <= '0;
      r_file_id   <= '0;
      r_digit_cnt <= '0;
      r_running   <= 1'b0;
      r_speed     <= '0;
    end else begin
      if (w_digit_valid && !r_running) begin
        if (r_digit_cnt < DigW'(ID_DIGITS)) begin
          r_entry     <= w_sat;
          r_file_id   <= w_sat;
          r_digit_cnt <= r_digit_cnt + DigW'(1);
        end else begin
          r_entry     <= ID_WIDTH'(w_digit);
          r_file_id   <= ID_WIDTH'(w_digit);
          r_digit_cnt <= DigW'(1);
        end
      end
      if (w_is_bksp || w_is_clear) begin
        r_entry     <= '0;
        r_digit_cnt <= '0;
      end
      if (w_is_start) begin
        r_running   <= 1'b1;
        r_digit_cnt <= '0;
      end
      if (w_is_pause || w_is_clear) r_running <= 1'b0;
      if (w_is_up && (r_speed != {SPEED_WIDTH{1'b1}})) r_speed <= r_speed + SPEED_WIDTH'(1);
      if (w_is_down && (r_speed != '0))                r_speed <= r_speed - SPEED_WIDTH'(1);
    end
  end

  // Any new command reloads the window and replaces whichever output was active.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_cmd       <= 3'b000;
      r_pulse_cnt <= '0;
    end else if (w_is_start || w_is_pause || w_is_clear) begin
      r_cmd       <= {w_is_start, w_is_pause, w_is_clear};
      r_pulse_cnt <= CntW'(PULSE_CYCLES);
    end else if (r_pulse_cnt != '0) begin
      r_pulse_cnt <= r_pulse_cnt - CntW'(1);
      if (r_pulse_cnt == CntW'(1)) r_cmd <= 3'b000;
    end
  end

  assign start   = r_cmd[2];
  assign pause   = r_cmd[1];
  assign clear   = r_cmd[0];
  assign running = r_running;
  assign file_id = r_file_id;
  assign speed   = r_speed;

endmodule
